// File: rtl/lisp_defs.sv
// Shared Lisp heap definitions: cell type tags, NIL, walker error causes.
package lisp_defs;

    localparam int TYPE_W = 3;
    localparam int HDR_TYPE_LSB = 12;

    localparam logic [TYPE_W-1:0] TYPE_NUMBER = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_CONS = 3'd2;

    localparam logic [15:0] LISP_NIL = 16'h0000;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NOT_LIST   = 2'd1,
        ERR_NOT_NUMBER = 2'd2,
        ERR_TOO_LONG   = 2'd3
    } walker_err_t;

endpackage

// File: rtl/list_walker_if.sv
// Memory read port and element output stream of the list walker.
interface list_walker_if;

    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic [14:0] mem_header;
    logic [15:0] mem_car;
    logic [15:0] mem_cdr;
    logic        mem_done;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    modport master (
        output mem_read_enable,
        output mem_addr,
        input  mem_header,
        input  mem_car,
        input  mem_cdr,
        input  mem_done,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_read_enable,
        input  mem_addr,
        output mem_header,
        output mem_car,
        output mem_cdr,
        output mem_done,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/list_walker.sv
// Walks a Lisp list's cdr chain and streams the number in each car.
module list_walker
    import lisp_defs::*;
#(
    parameter int MaxLen = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   root_ptr,
    output logic          busy,
    list_walker_if.master bus,
    output logic          done,
    output logic          error,
    output logic [1:0]    error_code,
    output logic [15:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_CONS,
        S_WAIT_CONS,
        S_REQ_ELEM,
        S_WAIT_ELEM,
        S_EMIT,
        S_FINISH,
        S_FAIL
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MaxLen);

    state_t      state;
    state_t      state_d;

    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic        load_addr;
    logic [15:0] next_q;
    logic [15:0] data_q;
    logic        last_q;
    logic [15:0] count_q;
    walker_err_t err_q;
    walker_err_t fail_d;

    logic        clr;
    logic        cap_cons;
    logic        cap_elem;
    logic        inc;
    logic        set_fail;

    logic [TYPE_W-1:0] hdr_type;
    logic              hdr_unused;

    assign hdr_type   = bus.mem_header[HDR_TYPE_LSB +: TYPE_W];
    assign hdr_unused = ^bus.mem_header[HDR_TYPE_LSB-1:0];

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        load_addr = 1'b0;
        clr       = 1'b0;
        cap_cons  = 1'b0;
        cap_elem  = 1'b0;
        inc       = 1'b0;
        set_fail  = 1'b0;
        fail_d    = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (root_ptr == LISP_NIL) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d   = S_REQ_CONS;
                        load_addr = 1'b1;
                        addr_d    = root_ptr;
                    end
                end
            end
            S_REQ_CONS: state_d = S_WAIT_CONS;
            S_WAIT_CONS: begin
                if (bus.mem_done) begin
                    if (hdr_type != TYPE_CONS) begin
                        state_d  = S_FAIL;
                        set_fail = 1'b1;
                        fail_d   = ERR_NOT_LIST;
                    end else begin
                        state_d   = S_REQ_ELEM;
                        cap_cons  = 1'b1;
                        load_addr = 1'b1;
                        addr_d    = bus.mem_car;
                    end
                end
            end
            S_REQ_ELEM: state_d = S_WAIT_ELEM;
            S_WAIT_ELEM: begin
                if (bus.mem_done) begin
                    if (hdr_type != TYPE_NUMBER) begin
                        state_d  = S_FAIL;
                        set_fail = 1'b1;
                        fail_d   = ERR_NOT_NUMBER;
                    end else begin
                        state_d  = S_EMIT;
                        cap_elem = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    inc = 1'b1;
                    if (next_q == LISP_NIL) begin
                        state_d = S_FINISH;
                    end else if (count_q + 16'd1 == MAX_CNT) begin
                        // Runaway guard: a cyclic cdr chain ends here.
                        state_d  = S_FAIL;
                        set_fail = 1'b1;
                        fail_d   = ERR_TOO_LONG;
                    end else begin
                        state_d   = S_REQ_CONS;
                        load_addr = 1'b1;
                        addr_d    = next_q;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            next_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            if (load_addr) begin
                addr_q <= addr_d;
            end
            if (cap_cons) begin
                next_q <= bus.mem_cdr;
            end
            if (cap_elem) begin
                data_q <= bus.mem_car;
                last_q <= (next_q == LISP_NIL);
            end
            if (clr) begin
                count_q <= '0;
                err_q   <= ERR_NONE;
            end else if (inc) begin
                count_q <= count_q + 16'd1;
            end
            if (set_fail) begin
                err_q <= fail_d;
            end
        end
    end

    assign busy = (state == S_REQ_CONS) || (state == S_WAIT_CONS)
               || (state == S_REQ_ELEM) || (state == S_WAIT_ELEM)
               || (state == S_EMIT);

    assign bus.mem_read_enable = (state == S_REQ_CONS)
                              || (state == S_REQ_ELEM);
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = (state == S_EMIT);
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;

    assign done       = (state == S_FINISH);
    assign error      = (state == S_FAIL);
    assign error_code = err_q;
    assign count      = count_q;

endmodule
